// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int unsigned MEM_BYTES_DEF = 512;
  localparam int unsigned TIMEOUT_DEF   = 31;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable watchdog counter: clear, load, count-enable and an expired flag
// that fires on the LIMIT-th enabled cycle.
module mem_arb_timeout #(
  parameter int unsigned LIMIT = 31,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins over load, load over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-fetch and D-load/store ports onto one memory with a
// request/MOC handshake. Round-robin arbitration: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_moc
);

  localparam int unsigned     CNT_W    = cnt_width(TIMEOUT);
  localparam logic [ADDR_W:0] LAST_OFS = (ADDR_W + 1)'(3);
  localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W + 1)'(MEM_BYTES);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              sel_gnt_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [ADDR_W:0]   end_addr_s;
  logic              legal_s;
  logic              expired_s;

  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  gnt_e              last_q, last_d;
`endif

  mem_arb_timeout #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == IDLE),
    .load     (state_q == ISSUE),
    .load_val ('0),
    .en       (state_q == WAIT),
    .expired  (expired_s)
  );

  // Pick the requester and check its access; the end address is one bit wider
  // so an address near the top of the space cannot wrap into range.
  always_comb begin
    sel_gnt_s = GNT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      sel_gnt_s = (last_q == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req) begin
      sel_gnt_s = GNT_D;
    end else begin
      sel_gnt_s = GNT_I;
    end
`else
    if (d_req) begin
      sel_gnt_s = GNT_D;
    end else begin
      sel_gnt_s = GNT_I;
    end
`endif
    if (sel_gnt_s == GNT_D) begin
      sel_addr_s  = d_addr;
      sel_we_s    = d_we;
      sel_wdata_s = d_wdata;
    end else begin
      sel_addr_s  = i_addr;
      sel_we_s    = 1'b0;
      sel_wdata_s = '0;
    end
    end_addr_s = {1'b0, sel_addr_s} + LAST_OFS;
    legal_s    = (sel_addr_s[1:0] == 2'b00) && (end_addr_s < MEM_LIM);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = '0;
    d_rdata_d   = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d = sel_gnt_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = sel_gnt_s;
`endif
          if (legal_s) begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = sel_we_s;
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = sel_wdata_s;
          end else begin
            state_d = RESP;
            i_ack_d = (sel_gnt_s == GNT_I);
            d_ack_d = (sel_gnt_s == GNT_D);
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the last allowed cycle still counts as success.
        if (mem_moc || expired_s) begin
          state_d     = RESP;
          i_ack_d     = (gnt_q == GNT_I);
          d_ack_d     = (gnt_q == GNT_D);
          err_d       = !mem_moc;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (mem_moc && (gnt_q == GNT_I)) begin
            i_rdata_d = mem_rdata;
          end else begin
            i_rdata_d = '0;
          end
          if (mem_moc && (gnt_q == GNT_D) && !mem_we_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = '0;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // State, grant and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-grant pointer; reset so that I wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_D;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, contention and
// reset sequences, and randomized transactions against a behavioural model.
module tb_mem_port_arbiter;

  localparam int          TIMEOUT = 31;
  localparam logic [31:0] JUNK    = 32'hBAD0_BAD0;
  localparam logic [31:0] KEY     = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_moc;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int exp_last;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_moc   (mem_moc)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdat;
    logic        exp_err;
    int          exp_cyc;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Expected outcome straight from the rules: legality, then MOC vs watchdog.
  function automatic void model(input int port, input logic we, input logic [31:0] addr,
                                input int dly, input logic [31:0] rdat,
                                output logic e, output int cyc, output logic [31:0] rd);
    longint unsigned a;
    a = longint'(addr);
    if ((a % 4) != 0 || (a + 3) >= 512) begin
      e = 1'b1; cyc = 1; rd = 32'h0;
    end else if (dly <= TIMEOUT) begin
      e = 1'b0; cyc = dly + 2; rd = (port == 1 && we) ? 32'h0 : rdat;
    end else begin
      e = 1'b1; cyc = TIMEOUT + 2; rd = 32'h0;
    end
  endfunction

  // One transaction on one port; memory answers dly cycles after mem_req.
  task automatic do_txn(input string name, input int port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input int dly,
                        input logic [31:0] rdat, input logic drop, input logic exp_err,
                        input int exp_cyc, input logic [31:0] exp_rd);
    int          n = 0;
    int          req_at = -1;
    int          ack_at = -1;
    int          reqs = 0;
    logic [1:0]  ack_ports = 2'b00;
    logic        got_err = 1'b0;
    logic [31:0] got_rd = 32'h0;
    if (port == 1) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    while (n < TIMEOUT + 8 && ack_at < 0) begin
      @(posedge clk); @(negedge clk);
      n++;
      mem_moc = 1'b0; mem_rdata = JUNK;
      if (i_ack || d_ack) begin
        ack_at    = n;
        ack_ports = {i_ack, d_ack};
        got_err   = err;
        got_rd    = (port == 1) ? d_rdata : i_rdata;
        i_req = 1'b0; d_req = 1'b0;
      end else begin
        if (mem_req) begin
          reqs++;
          req_at = n;
          if (drop) begin
            i_req = 1'b0; d_req = 1'b0;
          end
        end
        if (req_at > 0) begin
          chk({name, "_mem_we"}, 32'(mem_we), 32'(we));
          chk({name, "_mem_addr"}, mem_addr, addr);
          if (we) chk({name, "_mem_wdata"}, mem_wdata, wdata);
        end
        if (req_at > 0 && n == req_at + dly) begin
          mem_moc = 1'b1; mem_rdata = rdat;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk({name, "_ack_cycle"}, 32'(ack_at), 32'(exp_cyc));
    chk({name, "_ack_port"}, 32'(ack_ports), (port == 1) ? 32'h1 : 32'h2);
    chk({name, "_err"}, 32'(got_err), 32'(exp_err));
    chk({name, "_rdata"}, got_rd, exp_rd);
    chk({name, "_mem_req_count"}, 32'(reqs), (exp_cyc == 1) ? 32'h0 : 32'h1);
    @(posedge clk); @(negedge clk);
    mem_moc = 1'b0; mem_rdata = JUNK;
    chk({name, "_ack_pulse"}, {30'd0, i_ack, d_ack}, 32'h0);
    exp_last = port;
  endtask

  // Both ports request together; check service order and returned words.
  task automatic dual(input string name);
    int exp_first;
    int order[$];
    int n = 0;
    int pend = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first = (exp_last == 1) ? 0 : 1;
`else
    exp_first = 1;
`endif
    i_req = 1'b1; i_addr = 32'h0000_0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    while (n < 200 && order.size() < 2) begin
      @(posedge clk); @(negedge clk);
      n++;
      mem_moc = 1'b0; mem_rdata = JUNK;
      if (i_ack) begin
        order.push_back(0);
        chk({name, "_i_rdata"}, i_rdata, 32'h0000_0010 ^ KEY);
        i_req = 1'b0;
      end
      if (d_ack) begin
        order.push_back(1);
        chk({name, "_d_rdata"}, d_rdata, 32'h0000_0020 ^ KEY);
        d_req = 1'b0;
      end
      if (mem_req) begin
        pend = n;
      end else if (pend >= 0 && n == pend + 1) begin
        mem_moc = 1'b1; mem_rdata = mem_addr ^ KEY; pend = -1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk({name, "_ack_count"}, 32'(order.size()), 32'h2);
    if (order.size() == 2) begin
      chk({name, "_first"}, 32'(order[0]), 32'(exp_first));
      chk({name, "_second"}, 32'(order[1]), 32'(1 - exp_first));
      exp_last = order[1];
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int          port, dly, sel;
    logic        we, drop, e;
    logic [31:0] addr, wdata, rdat, rd;
    int          cyc;
    logic        seen, bad;

    rst_n = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_moc = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = JUNK;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_ctrl", {27'd0, i_ack, d_ack, err, mem_req, mem_we}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rdata", i_rdata | d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = 1;

    vecs.push_back('{0, 1'b0, 32'h0000_000C, 32'h0,         3,  32'h8C22_0004, 1'b0, 5, 32'h8C22_0004});
    vecs.push_back('{1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2,  32'h1357_9BDF, 1'b0, 4, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h0000_01FC, 32'h0,         1,  32'h1234_5678, 1'b0, 3, 32'h1234_5678});
    vecs.push_back('{1, 1'b0, 32'h0000_0102, 32'h0,         1,  32'h1111_1111, 1'b1, 1, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h0000_01FE, 32'hCAFE_F00D, 1,  32'h2222_2222, 1'b1, 1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0200, 32'h0,         1,  32'h3333_3333, 1'b1, 1, 32'h0});
    vecs.push_back('{1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1,  32'h4444_4444, 1'b1, 1, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_01F0, 32'h0,         1,  32'hA5A5_C3C3, 1'b0, 3, 32'hA5A5_C3C3});
    vecs.push_back('{1, 1'b0, 32'h0000_0000, 32'h0,         99, 32'h5555_5555, 1'b1, TIMEOUT + 2, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h0000_0004, 32'h0,         1,  32'h6666_6666, 1'b0, 3, 32'h6666_6666});
    vecs.push_back('{1, 1'b0, 32'h0000_0008, 32'h0,   TIMEOUT,  32'h7777_7777, 1'b0, TIMEOUT + 2, 32'h7777_7777});
    foreach (vecs[k]) begin
      do_txn($sformatf("vec%0d", k), vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata,
             vecs[k].dly, vecs[k].rdat, 1'b0, vecs[k].exp_err, vecs[k].exp_cyc, vecs[k].exp_rd);
    end

    dual("dual0");
    dual("dual1");

    for (int k = 0; k < 40; k++) begin
      port = int'($urandom_range(0, 1));
      we   = (port == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      sel  = int'($urandom_range(0, 9));
      if (sel < 6) addr = 32'($urandom_range(0, 127) * 4);
      else if (sel < 9) addr = 32'($urandom_range(0, 32'h210));
      else addr = $urandom;
      dly   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                          : int'($urandom_range(1, 5));
      wdata = $urandom;
      rdat  = $urandom;
      drop  = ($urandom_range(0, 3) == 0);
      model(port, we, addr, dly, rdat, e, cyc, rd);
      do_txn($sformatf("rand%0d", k), port, we, addr, wdata, dly, rdat, drop, e, cyc, rd);
    end

    // Reset in the middle of a store's WAIT phase, then a late MOC.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'h1122_3344;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("rst_seq_mem_req", 32'(seen), 32'h1);
    @(posedge clk); @(negedge clk);
    chk("rst_seq_in_wait", {31'd0, mem_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {27'd0, i_ack, d_ack, err, mem_req, mem_we}, 32'h0);
    chk("rst_async_mem_addr", mem_addr, 32'h0);
    chk("rst_async_mem_wdata", mem_wdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_moc = 1'b1; mem_rdata = 32'h9999_9999;
    bad = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); @(negedge clk);
      mem_moc = 1'b0; mem_rdata = JUNK;
      bad = bad | i_ack | d_ack | mem_req | err;
    end
    chk("late_moc_quiet", 32'(bad), 32'h0);
    exp_last = 1;
    do_txn("post_rst", 1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'hFEED_0001, 1'b0,
           1'b0, 4, 32'hFEED_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the shared 512-byte, byte-addressed, big-endian unified memory between two requesters: the instruction fetch (I) port and the data load/store (D) port.
- Runs the memory-side request / MOC (memory operation complete) handshake.
- Checks alignment and range before issuing, and recovers from a memory that never completes via a timeout watchdog.
- Sits between the control unit's fetch/memory stages and the RAM model.

Parameters:
- ADDR_W, 32, requester and memory address width
- DATA_W, 32, word width (4 bytes, big-endian)
- MEM_BYTES, 512, memory size; legal word address is addr+3 < MEM_BYTES
- TIMEOUT, 31, maximum cycles spent in WAIT before an error completion

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address (PC)
- i_ack  out  1  one-cycle completion pulse for I
- i_rdata  out  DATA_W  fetched word, valid only while i_ack=1
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for D
- d_rdata  out  DATA_W  load data, valid only while d_ack=1
- err  out  1  error flag for the acked transaction, valid with i_ack or d_ack
- mem_req  out  1  one-cycle strobe that starts a memory operation
- mem_we  out  1  memory write enable, held from ISSUE through WAIT
- mem_addr  out  ADDR_W  latched address, held from ISSUE through WAIT
- mem_wdata  out  DATA_W  latched store data, held from ISSUE through WAIT
- mem_rdata  in  DATA_W  memory read word, sampled when mem_moc=1
- mem_moc  in  1  operation complete, high for at least one cycle

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0, including mem_addr, mem_wdata, i_rdata and d_rdata.
  - Timeout counter cleared; round-robin pointer (if compiled in) reset to favour I.
- FSM states:
  - IDLE → ISSUE when any request is present and the latched access is legal; → RESP when the latched access is illegal (err=1, no memory access).
  - ISSUE: mem_req=1 for exactly one cycle → WAIT.
  - WAIT: counter increments each cycle. mem_moc=1 → capture mem_rdata, → RESP. Counter reaches TIMEOUT → RESP with err=1.
  - RESP: pulse the granted ack for one cycle with rdata and err → IDLE.
- Arbitration: in IDLE, D has fixed priority over I.
- The grant, address, we and wdata are latched on leaving IDLE. Requester inputs are ignored until the next IDLE.
- Legality:
  - addr[1:0] must be 00.
  - addr+3 must be < MEM_BYTES; compute in ADDR_W+1 bits so wrap-around never passes the check.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1 → earliest mem_moc at cycle 2 → ack at cycle 3. Illegal access: ack with err at cycle 1.
- mem_moc outside WAIT is ignored.
- Requests that arrive in RESP are evaluated in the next IDLE; there is no back-to-back grant from RESP.
- Loads return the word unchanged; byte ordering is the memory's job. Stores never drive rdata (it stays 0).
- A requester dropping req mid-transaction does not abort it; the ack is still produced.
- Reset mid-operation abandons the transaction immediately, with no ack.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a one-bit last-grant pointer is kept. When both requests are present, the port not granted last wins. The pointer updates on each legal or illegal grant.
- Undefined: fixed D-over-I priority; the pointer logic is absent.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), grant enum (GNT_I, GNT_D), default MEM_BYTES and TIMEOUT constants.
- One natural sub-module, mem_arb_timeout: a loadable counter with clear, enable and expired output.

Test Plan:
- I-only read at i_addr=0x00C, mem_moc 3 cycles after mem_req, mem_rdata=0x8C220004 → i_ack once, i_rdata=0x8C220004, err=0, mem_we=0.
- D store at d_addr=0x100, d_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until mem_moc; d_ack with err=0, d_rdata=0.
- i_req and d_req asserted together, fixed priority → D served first, then I. With MEM_ARB_ROUND_ROBIN_EN and last grant=D → I served first.
- d_addr=0x102 and d_addr=0x1FE → no mem_req, d_ack at cycle 1 with err=1. d_addr=0x1FC → legal.
- mem_moc never asserted → ack with err=1 after TIMEOUT cycles in WAIT; the next request then proceeds normally.
- rst_n pulsed low during WAIT → outputs 0 asynchronously, no ack; a late mem_moc is ignored.
